// File: rtl/pa_bus.sv
// Shared types and defaults for the external bus interface unit.
// Holds the controller state encoding, region encoding and timing constants.
package pa_bus;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DMA_REQ,
    ST_DMA_GNT,
    ST_DMA_REL
  } e_bus_state;

  typedef enum logic [1:0] {
    RG_ROM,
    RG_RAM,
    RG_IO
  } e_bus_region;

  localparam int WAIT_W = 4;

  localparam int DEF_ROM_WAIT = 2;
  localparam int DEF_RAM_WAIT = 1;
  localparam int DEF_IO_WAIT  = 3;
  localparam int DEF_TIMEOUT  = 64;

  localparam logic [21:0] DEF_ROM_LIMIT = 22'h00_8000;

endpackage

// File: rtl/bus_region_decode.sv
// Maps a CPU address and memory/IO select onto a bus region
// and the number of extra strobe cycles that region needs.
module bus_region_decode
  import pa_bus::*;
#(
  parameter int          ROM_WAIT  = DEF_ROM_WAIT,
  parameter int          RAM_WAIT  = DEF_RAM_WAIT,
  parameter int          IO_WAIT   = DEF_IO_WAIT,
  parameter logic [21:0] ROM_LIMIT = DEF_ROM_LIMIT
) (
  input  logic [21:0]       addr,
  input  logic              mem_io,
  output e_bus_region       region,
  output logic [WAIT_W-1:0] wait_n
);

  always_comb begin
    region = RG_RAM;
    wait_n = WAIT_W'(RAM_WAIT);
    unique case (1'b1)
      !mem_io: begin
        region = RG_IO;
        wait_n = WAIT_W'(IO_WAIT);
      end
      mem_io && (addr < ROM_LIMIT): begin
        region = RG_ROM;
        wait_n = WAIT_W'(ROM_WAIT);
      end
      mem_io && (addr >= ROM_LIMIT): begin
        region = RG_RAM;
        wait_n = WAIT_W'(RAM_WAIT);
      end
    endcase
  end

endmodule

// File: rtl/bus_controller.sv
// Bus interface unit: turns CPU rd/wr levels into timed ROM/RAM/IO
// cycles with wait states, ready stretching, timeout and DMA handover.
module bus_controller
  import pa_bus::*;
#(
  parameter int          ROM_WAIT  = DEF_ROM_WAIT,
  parameter int          RAM_WAIT  = DEF_RAM_WAIT,
  parameter int          IO_WAIT   = DEF_IO_WAIT,
  parameter logic [21:0] ROM_LIMIT = DEF_ROM_LIMIT,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_mem_io,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_wait,
  output logic        cpu_dma_req,
  input  logic        cpu_dma_ack,
  input  logic        ext_dma_req,
  output logic        ext_dma_ack,
  output logic [21:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_in,
  output logic        bus_rom_cs_n,
  output logic        bus_ram_cs_n,
  output logic        bus_io_cs_n,
  output logic        bus_oe_n,
  output logic        bus_we_n,
  input  logic        bus_ready,
  output logic        bus_own,
  output logic        bus_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  e_bus_state        state;
  e_bus_region       region;
  logic [WAIT_W-1:0] wait_n;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] cnt;
  logic [TW-1:0]     tcnt;

  logic req_lvl, req_prev, rise;
  logic pend, pend_wr, req, req_wr, wr_q;
  logic st_done, st_tout;

  bus_region_decode #(
    .ROM_WAIT  (ROM_WAIT),
    .RAM_WAIT  (RAM_WAIT),
    .IO_WAIT   (IO_WAIT),
    .ROM_LIMIT (ROM_LIMIT)
  ) u_dec (
    .addr   (cpu_addr),
    .mem_io (cpu_mem_io),
    .region (region),
    .wait_n (wait_n)
  );

  // rd and wr together is not a request and must not arm the detector
  assign req_lvl = cpu_rd ^ cpu_wr;
  assign rise    = req_lvl & ~req_prev;
  assign req     = rise | pend;
  assign req_wr  = rise ? cpu_wr : pend_wr;
  assign st_done = (cnt == '0) && bus_ready;
  assign st_tout = !st_done && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (arst) begin
      state        <= ST_IDLE;
      req_prev     <= req_lvl;
      pend         <= 1'b0;
      pend_wr      <= 1'b0;
      wr_q         <= 1'b0;
      wait_q       <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      cpu_data_in  <= 8'h00;
      cpu_wait     <= 1'b0;
      cpu_dma_req  <= 1'b0;
      ext_dma_ack  <= 1'b0;
      bus_addr     <= '0;
      bus_data_out <= 8'h00;
      bus_data_oe  <= 1'b0;
      bus_rom_cs_n <= 1'b1;
      bus_ram_cs_n <= 1'b1;
      bus_io_cs_n  <= 1'b1;
      bus_oe_n     <= 1'b1;
      bus_we_n     <= 1'b1;
      bus_own      <= 1'b1;
      bus_err      <= 1'b0;
    end else begin
      req_prev <= req_lvl;
      bus_err  <= 1'b0;
      pend     <= pend | rise;
      if (rise) pend_wr <= cpu_wr;
      unique case (state)
        ST_IDLE: begin
          if (ext_dma_req) begin
            state       <= ST_DMA_REQ;
            cpu_dma_req <= 1'b1;
          end else if (req) begin
            state        <= ST_SETUP;
            pend         <= 1'b0;
            wr_q         <= req_wr;
            wait_q       <= wait_n;
            bus_addr     <= cpu_addr;
            bus_data_out <= cpu_data_out;
            bus_data_oe  <= req_wr;
            cpu_wait     <= 1'b1;
            bus_rom_cs_n <= region != RG_ROM;
            bus_ram_cs_n <= region != RG_RAM;
            bus_io_cs_n  <= region != RG_IO;
          end
        end
        ST_SETUP: begin
          state <= ST_STROBE;
          cnt   <= wait_q;
          tcnt  <= '0;
          if (wr_q) bus_we_n <= 1'b0;
          else      bus_oe_n <= 1'b0;
        end
        ST_STROBE: begin
          if (st_done || st_tout) begin
            state    <= ST_HOLD;
            bus_oe_n <= 1'b1;
            bus_we_n <= 1'b1;
            cpu_wait <= 1'b0;
            bus_err  <= st_tout;
            if (!wr_q)
              cpu_data_in <= st_tout ? 8'hFF : bus_data_in;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (cnt != '0) cnt <= cnt - WAIT_W'(1);
          end
        end
        ST_HOLD: begin
          state        <= ST_IDLE;
          bus_data_oe  <= 1'b0;
          bus_rom_cs_n <= 1'b1;
          bus_ram_cs_n <= 1'b1;
          bus_io_cs_n  <= 1'b1;
        end
        ST_DMA_REQ: begin
          if (cpu_dma_ack) begin
            state       <= ST_DMA_GNT;
            ext_dma_ack <= 1'b1;
            bus_own     <= 1'b0;
          end
        end
        ST_DMA_GNT: begin
          if (!ext_dma_req) begin
            state       <= ST_DMA_REL;
            ext_dma_ack <= 1'b0;
            cpu_dma_req <= 1'b0;
            bus_own     <= 1'b1;
          end
        end
        ST_DMA_REL: begin
          if (!cpu_dma_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
